// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop process
// WIDTH operand bits LSB first, then publish sum, carry and signed overflow.
module serial_add_sub #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             c;

   logic             s_bit;
   logic             c_nxt;
   logic             last;
   logic [WIDTH-1:0] acc_nxt;

   always_comb begin
      s_bit   = sa[0] ^ sb[0] ^ c;
      c_nxt   = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
      last    = (cnt == CNT_W'(WIDTH - 1));
      acc_nxt = {s_bit, acc[WIDTH-1:1]};
   end

   // Subtraction is A + ~B + 1: B is inverted on load and the carry seeded with 1.
   // acc is the working shift register so the visible sum stays stable during RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sa        <= '0;
         sb        <= '0;
         acc       <= '0;
         cnt       <= '0;
         c         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= sub ? ~b : b;
                  c     <= sub;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               c   <= c_nxt;
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               acc <= acc_nxt;
               cnt <= cnt + CNT_W'(1);
               if (last) begin
                  // On the MSB, c is the carry in and c_nxt the carry out.
                  sum       <= acc_nxt;
                  carry_out <= c_nxt;
                  overflow  <= c ^ c_nxt;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor; the sequential, multi-bit successor to the single-bit half adder in the user project.
- Captures two WIDTH-bit operands on a start request and processes one bit per enabled clock, LSB first, through a single full-adder slice and a carry flop.
- Reports sum, carry/borrow and signed overflow with a one-cycle done pulse.
- Sits inside the tt_um top; operands and controls come from ui_in/uio_in, results drive uo_out/uio_out.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  design enable; when low, all state holds.
- start  input  1  request a new operation; sampled only when idle and ena=1.
- sub  input  1  0 = A+B, 1 = A−B; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result register.
- carry_out  output  1  final carry (for subtraction: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow of the last operation.

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assert, active-low; release is synchronous to clk in the top.
- Reset values: state IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0. Operand shift registers, carry flop and counter are cleared.
- States: IDLE, RUN. There is no DONE state; done is a registered pulse.

IDLE:
- On an edge with ena=1 and start=1:
  - load A into sa.
  - load B into sb, or ~B into sb when sub=1.
  - carry flop c <= sub.
  - counter <= 0.
  - done <= 0; busy <= 1.
  - go to RUN.
- In all other cases, state and outputs hold, except done, which clears after one cycle.

RUN: each edge with ena=1:
- s = sa[0]^sb[0]^c.
- c <= majority(sa[0], sb[0], c).
- sa and sb shift right by 1.
- Result shift register shifts right with s inserted at bit WIDTH−1.
- counter increments.

Last bit (counter == WIDTH−1):
- sum <= final shifted value.
- carry_out <= new carry.
- overflow <= (carry into MSB) XOR (carry out of MSB).
- busy <= 0; done <= 1 for exactly one cycle; go to IDLE.

Latency:
- start is sampled at edge E0.
- Bits are processed at edges E1..EWIDTH.
- done and the valid sum appear after EWIDTH, i.e. WIDTH enabled cycles after E0.

Holding and stalls:
- sum, carry_out and overflow hold their values until the next operation completes.
- The visible sum does not change during RUN: the internal shift register is separate from sum.
- ena=0 in any state freezes all registers, including a pending done pulse. The done pulse is extended until the next enabled edge.

Boundary cases:
- start while busy is ignored; operands are not re-sampled.
- start on the same edge that done is set is accepted only from IDLE, so back-to-back operations have a one-cycle gap.
- rst_n low mid-operation aborts immediately to reset values; no done pulse is produced.

Arithmetic:
- Pure modulo-2^WIDTH arithmetic; no saturation.

Test Plan:
- WIDTH=8, add 0x3C+0x05 → sum=0x41, carry_out=0, overflow=0. busy is high for exactly 8 cycles; done pulses once, 8 cycles after the start edge.
- Add 0xFF+0x01 → sum=0x00, carry_out=1, overflow=0. Add 0x7F+0x01 → sum=0x80, carry_out=0, overflow=1.
- Sub 0x05−0x07 → sum=0xFE, carry_out=0 (borrow), overflow=0. Sub 0x80−0x01 → sum=0x7F, carry_out=1, overflow=1.
- Add 0x12+0x34, with ena deasserted for 3 cycles mid-RUN and start pulsed while busy → done arrives 11 cycles after start, sum=0x46, and the second start has no effect.
- Run 0xAA+0x55 to completion (sum=0xFF). Then start 0x10+0x10 and assert rst_n=0 after 4 bits → all outputs read 0 immediately. After release, 0x01+0x01 gives sum=0x02 with the normal 8-cycle latency.
- WIDTH=4 instance, exhaustive add and sub over all 16×16 operand pairs → sum, carry_out and overflow match a reference model for every pair.
